// File: rtl/dem_elem_state.sv
// rtl/dem_elem_state.sv - per-element usage state bank for the 18-element DEM loop
//
// Holds one SW-bit usage count per unary DAC element. Each accepted update
// subtracts the MIN18 stage's minimum (min_in) from every count and then adds
// the element selection vector. This closes the loop state -> MIN18 ->
// normalise/accumulate -> state.
//
// Build option: DEM_ELEM_STATE_SAT_EN
//   defined     - a count reaching 16 saturates to 15
//   not defined - a count reaching 16 wraps to 0
//   ovf is set in both builds.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high (priority over clr)
//   clr        synchronous clear of state and flags (priority over in_valid)
//   in_valid   update strobe; sel, code and min_in sampled when high
//   sel        element selection vector, bit i fires element i
//   code       DAC input code 0..18, expected popcount of sel
//   min_in     combinational minimum of state_bus from the MIN18 stage
//   state_bus  element i count at [SW*i +: SW], registered
//   out_valid  high one cycle after an accepted update
//   ovf        sticky, some count reached 16
//   cnt_err    sticky, popcount(sel) != code or code > 18 on an update
module dem_elem_state #(
  parameter int NELEM = 18,
  parameter int SW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [NELEM-1:0]    sel,
  input  logic [4:0]          code,
  input  logic [SW-1:0]       min_in,
  output logic [NELEM*SW-1:0] state_bus,
  output logic                out_valid,
  output logic                ovf,
  output logic                cnt_err
);

  logic [NELEM*SW-1:0] state_q;
  logic [NELEM*SW-1:0] state_nxt;
  logic                any_full;
  logic [4:0]          pop;
  logic                code_bad;
  logic                accept;

  // Normalise and accumulate in one pass. The subtraction is a plain SW-bit
  // wrap so a broken min_in (larger than a count) produces the modular result
  // rather than anything special.
  always_comb begin
    state_nxt = '0;
    any_full  = 1'b0;
    for (int i = 0; i < NELEM; i++) begin
      logic [SW-1:0] d;
      logic [SW:0]   t;
      d = state_q[i*SW +: SW] - min_in;
      t = {1'b0, d} + {{SW{1'b0}}, sel[i]};
      if (t[SW]) any_full = 1'b1;
`ifdef DEM_ELEM_STATE_SAT_EN
      state_nxt[i*SW +: SW] = t[SW] ? {SW{1'b1}} : t[SW-1:0];
`else
      state_nxt[i*SW +: SW] = t[SW-1:0];
`endif
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NELEM; i++) begin
      pop = pop + {4'b0, sel[i]};
    end
  end

  assign code_bad = (pop != code) || (code > 5'd18);
  assign accept   = in_valid && !clr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q   <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      cnt_err   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (accept) begin
        state_q <= state_nxt;
        if (any_full) ovf     <= 1'b1;
        if (code_bad) cnt_err <= 1'b1;
      end
    end
  end

  assign state_bus = state_q;

endmodule

// File: tb/tb_dem_elem_state.sv
// tb/tb_dem_elem_state.sv - self-checking bench for dem_elem_state
module tb_dem_elem_state;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid;
  logic [17:0] sel;
  logic [4:0]  code;
  logic [3:0]  min_in;
  logic [71:0] state_bus;
  logic        out_valid, ovf, cnt_err;

  int checks   = 0;
  int failures = 0;

  int m[18];
  logic ovf_m, cnt_m, ov_m;

  always #5 clk = ~clk;

  dem_elem_state dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .sel(sel), .code(code), .min_in(min_in),
    .state_bus(state_bus), .out_valid(out_valid),
    .ovf(ovf), .cnt_err(cnt_err)
  );

  function automatic logic [71:0] pack_m();
    logic [71:0] b;
    for (int i = 0; i < 18; i++) b[i*4 +: 4] = 4'(m[i]);
    return b;
  endfunction

  function automatic int min_m();
    int r = m[0];
    for (int i = 1; i < 18; i++) if (m[i] < r) r = m[i];
    return r;
  endfunction

  function automatic int min_bus(logic [71:0] b);
    int r = 15;
    for (int i = 0; i < 18; i++) if (int'(b[i*4 +: 4]) < r) r = int'(b[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [17:0] rand_sel(int k);
    int idx[18];
    logic [17:0] s = '0;
    for (int i = 0; i < 18; i++) idx[i] = i;
    for (int i = 17; i > 0; i--) begin
      int j, tmp;
      j = int'($urandom_range(0, i));
      tmp = idx[i]; idx[i] = idx[j]; idx[j] = tmp;
    end
    for (int i = 0; i < k; i++) s[idx[i]] = 1'b1;
    return s;
  endfunction

  task automatic chk(string tag, logic [71:0] o, logic [71:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 18; i++) m[i] = 0;
    ovf_m = 1'b0; cnt_m = 1'b0; ov_m = 1'b0;
  endtask

  task automatic check_all(string tag);
    chk({tag, "_state"}, state_bus, pack_m());
    chk({tag, "_out_valid"}, {71'b0, out_valid}, {71'b0, ov_m});
    chk({tag, "_ovf"}, {71'b0, ovf}, {71'b0, ovf_m});
    chk({tag, "_cnt_err"}, {71'b0, cnt_err}, {71'b0, cnt_m});
  endtask

  // Apply one cycle of inputs, advance the reference, then compare.
  task automatic step(string tag, bit v, logic [17:0] s, int c, int mn, bit cl);
    int pc;
    in_valid = v; sel = s; code = 5'(c); min_in = 4'(mn); clr = cl;
    if (cl) begin
      model_clear();
    end else begin
      ov_m = v;
      if (v) begin
        pc = 0;
        for (int i = 0; i < 18; i++) pc += int'(s[i]);
        if (pc != c || c > 18) cnt_m = 1'b1;
        for (int i = 0; i < 18; i++) begin
          int t;
          t = ((m[i] - mn) & 15) + int'(s[i]);
          if (t == 16) begin
            ovf_m = 1'b1;
`ifdef DEM_ELEM_STATE_SAT_EN
            t = 15;
`else
            t = 0;
`endif
          end
          m[i] = t;
        end
      end
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; sel = '0; code = '0; min_in = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int c;

    // reset then idle
    do_reset();
    check_all("reset");
    for (int k = 0; k < 5; k++) step("idle", 0, 18'h0, 0, 0, 0);

    // single update
    step("single", 1, 18'h00007, 3, 0, 0);
    step("single_after", 0, 18'h0, 0, 0, 0);

    // build all-5 state, then normalise with min 5
    for (int k = 0; k < 5; k++) step("build5", 1, 18'h3FFFF, 18, 0, 0);
    step("build5_hold", 1, 18'h00000, 0, min_m() == 5 ? 0 : 0, 0);
    for (int k = 0; k < 5; k++) step("build5b", 1, 18'h3FFFF, 18, 0, 0);
    step("norm", 1, 18'h3FFFF, 18, min_m(), 0);

    // count error, sticky, then clr beats in_valid
    step("cnt_err", 1, 18'h00003, 4, min_m(), 0);
    step("cnt_err_sticky", 0, 18'h0, 0, 0, 0);
    step("bad_code", 1, 18'h3FFFF, 19, min_m(), 0);
    step("clr_prio", 1, 18'h3FFFF, 18, 0, 1);
    step("after_clr", 0, 18'h0, 0, 0, 0);

    // overflow of element 0
    for (int k = 0; k < 15; k++) step("fill0", 1, 18'h00001, 1, 0, 0);
    step("ovf", 1, 18'h00001, 1, 0, 0);
    step("ovf_sticky", 0, 18'h0, 0, 0, 0);

    // broken min input: wrap, cnt_err unaffected
    step("clr2", 0, 18'h0, 0, 0, 1);
    step("pre_brk", 1, 18'h0000F, 4, 0, 0);
    step("broken_min", 1, 18'h00030, 2, 3, 0);

    // rst beats clr and in_valid
    rst = 1'b1;
    step("rst_prio", 1, 18'h3FFFF, 18, 0, 1);
    rst = 1'b0;

    // closed loop with random codes and matching selections
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 7) == 0) step("loop_idle", 0, 18'h0, 0, 0, 0);
      c = int'($urandom_range(0, 18));
      step("loop", 1, rand_sel(c), c, min_m(), 0);
      chk("loop_min_le1", {71'b0, min_bus(state_bus) <= 1}, 72'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
